// File: rtl/ndmreset_pkg.sv
// Shared types for the debug-driven ndmreset sequencer.
// Imported by the sequencer top.
package ndmreset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ASSERT,
        ST_HOLD
    } ndmreset_state_e;

endpackage

// File: rtl/axi_outstanding_cnt.sv
// Saturating up/down counter of outstanding AXI transactions.
// ovf/udf pulse on an increment at the limit or a decrement at zero.
module axi_outstanding_cnt #(
    parameter int unsigned Max  = 16,
    parameter int unsigned CntW = $clog2(Max + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            dec,
    input  logic            clr,
    output logic [CntW-1:0] count,
    output logic            ovf,
    output logic            udf
);

    localparam logic [CntW-1:0] MaxV = CntW'(Max);

    logic [CntW-1:0] count_d;

    always_comb begin
        count_d = count;
        ovf     = 1'b0;
        udf     = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count == MaxV) ovf = 1'b1;
            else count_d = count + 1'b1;
        end else if (dec && !inc) begin
            if (count == '0) udf = 1'b1;
            else count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else count <= count_d;
    end

endmodule

// File: rtl/ndmreset_seq.sv
// Debug ndmreset sequencer: gate AXI requests, drain outstanding
// transactions (with optional timeout), then stretch ndmreset_n low.
module ndmreset_seq
    import ndmreset_pkg::*;
#(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned AssertCycles   = 32,
    parameter int unsigned DrainTimeout   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ndreset_req,
    input  logic [NumPorts-1:0] aw_hs,
    input  logic [NumPorts-1:0] ar_hs,
    input  logic [NumPorts-1:0] b_hs,
    input  logic [NumPorts-1:0] r_last_hs,
    output logic [NumPorts-1:0] block_o,
    output logic                ndmreset_n,
    output logic                busy_o,
    output logic                timeout_o,
    output logic                err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned StW  = $clog2(AssertCycles + 1);
    localparam int unsigned DrW  = $clog2(DrainTimeout + 2);
    localparam bit          TmoEn = (DrainTimeout != 0);

    localparam logic [StW-1:0] StLoad = StW'(AssertCycles);
    localparam logic [StW-1:0] StLast = StW'(1);
    localparam logic [DrW-1:0] DrLast =
        DrW'(TmoEn ? DrainTimeout - 1 : 0);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    ndmreset_state_e state_q, state_d;

    logic           req_q, req_qq;
    logic [StW-1:0] st_cnt_q, st_cnt_d;
    logic [DrW-1:0] dr_cnt_q, dr_cnt_d;
    logic           timeout_d, err_d;
    logic           cnt_clr, drained;

    logic [CntW-1:0]     wr_cnt [NumPorts];
    logic [CntW-1:0]     rd_cnt [NumPorts];
    logic [NumPorts-1:0] wr_ovf, wr_udf, rd_ovf, rd_udf;
    logic [NumPorts-1:0] wr_idle, rd_idle;

    assign cnt_clr = (state_q == ST_ASSERT);

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        axi_outstanding_cnt #(
            .Max  (MaxOutstanding),
            .CntW (CntW)
        ) u_wr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (aw_hs[i]),
            .dec   (b_hs[i]),
            .clr   (cnt_clr),
            .count (wr_cnt[i]),
            .ovf   (wr_ovf[i]),
            .udf   (wr_udf[i])
        );

        axi_outstanding_cnt #(
            .Max  (MaxOutstanding),
            .CntW (CntW)
        ) u_rd (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (ar_hs[i]),
            .dec   (r_last_hs[i]),
            .clr   (cnt_clr),
            .count (rd_cnt[i]),
            .ovf   (rd_ovf[i]),
            .udf   (rd_udf[i])
        );

        // Look ahead one cycle so DRAIN exits right after the last response.
        assign wr_idle[i] =
            (wr_cnt[i] == '0 && (!aw_hs[i] || b_hs[i])) ||
            (wr_cnt[i] == CntOne && b_hs[i] && !aw_hs[i]);
        assign rd_idle[i] =
            (rd_cnt[i] == '0 && (!ar_hs[i] || r_last_hs[i])) ||
            (rd_cnt[i] == CntOne && r_last_hs[i] && !ar_hs[i]);
    end

    assign drained = &{wr_idle, rd_idle};

    assign err_d = err_o | (|{wr_ovf, wr_udf, rd_ovf, rd_udf});

    always_comb begin
        state_d   = state_q;
        st_cnt_d  = st_cnt_q;
        dr_cnt_d  = '0;
        timeout_d = timeout_o;
        unique case (state_q)
            ST_IDLE: begin
                if (req_q && !req_qq) begin
                    state_d   = ST_DRAIN;
                    timeout_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                dr_cnt_d = dr_cnt_q + 1'b1;
                if (drained) begin
                    state_d  = ST_ASSERT;
                    st_cnt_d = StLoad;
                end else if (TmoEn && dr_cnt_q == DrLast) begin
                    state_d   = ST_ASSERT;
                    st_cnt_d  = StLoad;
                    timeout_d = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (st_cnt_q == StLast) state_d = ST_HOLD;
                else st_cnt_d = st_cnt_q - 1'b1;
            end
            ST_HOLD: begin
                if (!ndreset_req) state_d = ST_IDLE;
            end
        endcase
    end

    // Reset lands in ASSERT with a full stretch, so power-on resets too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ASSERT;
            st_cnt_q   <= StLoad;
            dr_cnt_q   <= '0;
            req_q      <= 1'b0;
            req_qq     <= 1'b0;
            block_o    <= {NumPorts{1'b1}};
            ndmreset_n <= 1'b0;
            busy_o     <= 1'b1;
            timeout_o  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_cnt_q   <= st_cnt_d;
            dr_cnt_q   <= dr_cnt_d;
            req_q      <= ndreset_req;
            req_qq     <= req_q;
            block_o    <= (state_d == ST_IDLE) ?
                          {NumPorts{1'b0}} : {NumPorts{1'b1}};
            ndmreset_n <= (state_d != ST_ASSERT);
            busy_o     <= (state_d != ST_IDLE);
            timeout_o  <= timeout_d;
            err_o      <= err_d;
        end
    end

endmodule

// File: tb/tb_ndmreset_seq.sv
// Bench for ndmreset_seq: directed sequences plus random traffic
// checked against a transaction-count model.
module tb_ndmreset_seq;

    localparam int NP  = 2;
    localparam int MO  = 16;
    localparam int AC  = 32;
    localparam int DT  = 64;
    localparam int LIM = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [NP-1:0] aw, ar, b, rl;
    logic [NP-1:0] block_o;
    logic          ndmreset_n, busy_o, timeout_o, err_o;

    int nchk = 0;
    int nerr = 0;
    int wc [NP];
    int rc [NP];
    bit merr;

    always #5 clk = ~clk;

    ndmreset_seq #(
        .NumPorts       (NP),
        .MaxOutstanding (MO),
        .AssertCycles   (AC),
        .DrainTimeout   (DT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ndreset_req (req),
        .aw_hs       (aw),
        .ar_hs       (ar),
        .b_hs        (b),
        .r_last_hs   (rl),
        .block_o     (block_o),
        .ndmreset_n  (ndmreset_n),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outstanding count rule: +1 request, -1 response, clamp to 0..MO.
    task automatic step(inout int c, input logic inc, input logic dec);
        if (inc && !dec) begin
            if (c == MO) merr = 1'b1;
            else c++;
        end else if (dec && !inc) begin
            if (c == 0) merr = 1'b1;
            else c--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            step(wc[p], aw[p], b[p]);
            step(rc[p], ar[p], rl[p]);
        end
        #1;
        aw = '0; ar = '0; b = '0; rl = '0;
    endtask

    task automatic count_hi(output int n);
        n = 0;
        while (ndmreset_n === 1'b1 && n < LIM) begin
            n++;
            tick();
        end
    endtask

    task automatic count_lo(output int n);
        n = 0;
        while (ndmreset_n === 1'b0 && n < LIM) begin
            n++;
            tick();
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            wc[p] = 0;
            rc[p] = 0;
        end
    endtask

    // Request, then answer every outstanding transaction one per cycle.
    task automatic seq_drain(input string tag);
        int t, n;
        bit done;
        t = 0;
        for (int p = 0; p < NP; p++) t += wc[p] + rc[p];
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        chk({tag, "_block"}, block_o, 3);
        chk({tag, "_tmo_clr"}, timeout_o, 0);
        n = 0;
        while (ndmreset_n === 1'b1 && n < LIM) begin
            done = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!done && wc[p] > 0) begin b[p] = 1'b1; done = 1'b1; end
                if (!done && rc[p] > 0) begin rl[p] = 1'b1; done = 1'b1; end
            end
            n++;
            tick();
        end
        chk({tag, "_drain_len"}, n, (t > 0) ? t : 1);
    endtask

    task automatic finish_hold(input string tag);
        chk({tag, "_hold_n"}, ndmreset_n, 1);
        chk({tag, "_hold_block"}, block_o, 3);
        chk({tag, "_hold_busy"}, busy_o, 1);
        tick();
        chk({tag, "_idle_busy"}, busy_o, 0);
        chk({tag, "_idle_block"}, block_o, 0);
    endtask

    task automatic random_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (wc[p] < 8 && $urandom_range(0, 2) == 0) aw[p] = 1'b1;
                if (wc[p] > 0 && $urandom_range(0, 2) == 0) b[p] = 1'b1;
                if (rc[p] < 8 && $urandom_range(0, 2) == 0) ar[p] = 1'b1;
                if (rc[p] > 0 && $urandom_range(0, 2) == 0) rl[p] = 1'b1;
            end
            tick();
            chk("rand_err", err_o, merr);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, first, blk;
        rst_n = 1'b0;
        req   = 1'b0;
        aw = '0; ar = '0; b = '0; rl = '0;
        merr = 1'b0;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ndm", ndmreset_n, 0);
        chk("rst_block", block_o, 3);
        chk("rst_busy", busy_o, 1);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_err", err_o, 0);

        // Power-on stretch
        rst_n = 1'b1;
        count_lo(a);
        chk("por_assert_len", a, AC);
        finish_hold("por");

        // One-cycle request with no traffic
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("idle_n1_block", block_o, 0);
        tick();
        chk("idle_n2_block", block_o, 3);
        chk("idle_n2_busy", busy_o, 1);
        count_hi(n);
        chk("idle_drain_len", n, 1);
        count_lo(a);
        chk("idle_assert_len", a, AC);
        finish_hold("idle");

        // Three writes on port 1, responses at +10/+20/+30
        repeat (3) begin
            aw = 2'b10;
            tick();
        end
        req = 1'b1;
        first = -1;
        blk = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (block_o === 2'b11 && blk < 0) blk = k;
            if (ndmreset_n === 1'b0) begin
                first = k;
                break;
            end
            if (k == 10 || k == 20 || k == 30) b = 2'b10;
            if (k == 5) req = 1'b0;
        end
        chk("drain_block_lat", blk, 2);
        chk("drain_assert_at", first, 31);
        chk("drain_tmo", timeout_o, 0);
        count_lo(a);
        chk("drain_assert_len", a, AC);
        finish_hold("drain");

        // Unanswered read forces a timeout; request held into HOLD
        ar = 2'b01;
        tick();
        req = 1'b1;
        tick();
        tick();
        chk("tmo_block", block_o, 3);
        count_hi(n);
        chk("tmo_drain_len", n, DT);
        chk("tmo_flag", timeout_o, 1);
        count_lo(a);
        chk("tmo_assert_len", a, AC);
        repeat (3) tick();
        chk("tmo_hold_level", busy_o, 1);
        req = 1'b0;
        finish_hold("tmo");
        clear_model();
        chk("tmo_sticky", timeout_o, 1);
        seq_drain("tmo_clr");
        count_lo(a);
        chk("tmo_clr_assert_len", a, AC);
        finish_hold("tmo_clr");

        // Simultaneous request/response keeps the count
        aw = 2'b01;
        tick();
        aw = 2'b01;
        tick();
        aw = 2'b01;
        b  = 2'b01;
        tick();
        chk("simul_err", err_o, 0);
        seq_drain("simul");
        count_lo(a);
        chk("simul_assert_len", a, AC);
        finish_hold("simul");

        // Saturation at the limit
        for (int i = 0; i < MO + 1; i++) begin
            aw = 2'b01;
            tick();
            if (i == MO - 1) chk("sat_err_before", err_o, 0);
        end
        chk("sat_err", err_o, merr);
        chk("sat_err_set", err_o, 1);
        seq_drain("sat");

        // Reset on cycle 10 of the stretch
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ndm", ndmreset_n, 0);
        chk("midrst_block", block_o, 3);
        chk("midrst_busy", busy_o, 1);
        chk("midrst_err", err_o, 0);
        chk("midrst_tmo", timeout_o, 0);
        merr = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_lo(a);
        chk("midrst_assert_len", a, AC);
        finish_hold("midrst");

        // Random traffic, then drain against the model counts
        repeat (2) begin
            random_traffic(200);
            seq_drain("rand");
            count_lo(a);
            chk("rand_assert_len", a, AC);
            finish_hold("rand");
        end

        // Response with count at zero
        chk("udf_err_before", err_o, 0);
        b = 2'b01;
        tick();
        chk("udf_err", err_o, merr);
        chk("udf_err_set", err_o, 1);
        seq_drain("udf");
        count_lo(a);
        chk("udf_assert_len", a, AC);
        finish_hold("udf");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ndmreset_seq.md
# ndmreset_seq

Debug-driven non-debug-module reset sequencer for the core shell. It replaces the direct `ndmreset_n = rst_n` tie with a controlled sequence. On a debug reset request it first blocks new AXI requests on `NumPorts` master ports, then waits for their outstanding transactions to drain (bounded by a timeout), and then asserts `ndmreset_n` for a fixed stretch. It sits between the core's `debug_ndreset` and the peripheral/interconnect reset tree, snooping the `dram` and `iobus` handshakes.

## Interface
Parameters:
- `NumPorts`, 2, number of AXI master ports snooped and gated.
- `MaxOutstanding`, 16, per-port, per-direction outstanding transaction limit; counter width is `$clog2(MaxOutstanding+1)`.
- `AssertCycles`, 32, cycles `ndmreset_n` is held low per sequence; must be ≥1.
- `DrainTimeout`, 1024, maximum DRAIN cycles; 0 disables the timeout (wait forever).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ndreset_req` in 1: level request from the debug module (`debug_ndreset`), synchronous to `clk`.
- `aw_hs` in `NumPorts`: `aw_valid & aw_ready` per port, taken after the gate.
- `ar_hs` in `NumPorts`: `ar_valid & ar_ready` per port.
- `b_hs` in `NumPorts`: `b_valid & b_ready` per port.
- `r_last_hs` in `NumPorts`: `r_valid & r_ready & r_last` per port.
- `block_o` out `NumPorts`: when high, the shell forces `aw_valid`/`ar_valid` low toward the slave. W, B and R are never gated.
- `ndmreset_n` out 1: active-low reset to peripherals and interconnect.
- `busy_o` out 1: high in any state other than IDLE.
- `timeout_o` out 1: sticky; set when a drain times out, cleared on the next entry to DRAIN.
- `err_o` out 1: sticky counter overflow or underflow; cleared only by `rst_n`.

## Operation
- States are IDLE, DRAIN, ASSERT and HOLD. The reset state is ASSERT, with the stretch counter loaded to `AssertCycles`, so power-on also yields a full stretch.
- **IDLE:**
  - `block_o=0`, `ndmreset_n=1`.
  - A rising edge of `ndreset_req` (req & !req_q) moves to DRAIN.
  - A request that is already high when IDLE is entered does not retrigger.
- **DRAIN:**
  - `block_o` is all ones and the drain counter counts up.
  - When every per-port write and read counter is 0, go to ASSERT.
  - If the drain counter reaches `DrainTimeout` (and `DrainTimeout` is nonzero), set `timeout_o` and go to ASSERT anyway.
  - If `ndreset_req` drops during DRAIN, continue; the sequence always completes.
- **ASSERT:**
  - `ndmreset_n=0`, `block_o` all ones.
  - All outstanding counters are forced to 0.
  - After `AssertCycles` cycles, go to HOLD.
- **HOLD:**
  - `ndmreset_n=1`, `block_o` all ones.
  - Wait for `ndreset_req==0`, then go to IDLE.
- **Outstanding counters:** per port there is a write counter (+1 on `aw_hs`, −1 on `b_hs`) and a read counter (+1 on `ar_hs`, −1 on `r_last_hs`).
  - Simultaneous increment and decrement leave the count unchanged.
  - Incrementing at `MaxOutstanding` saturates and sets `err_o`.
  - Decrementing at 0 holds 0 and sets `err_o`.
  - Counters keep counting in every state except ASSERT.
- Handshakes seen during DRAIN are counted normally; new AW/AR handshakes should not appear because the gate is active.

## Timing
- Reset values of outputs: `ndmreset_n=0`, `block_o` all ones, `busy_o=1`, `timeout_o=0`, `err_o=0`.
- All outputs are registered.
- Request to block latency:
  - `ndreset_req` rising in cycle N is registered into `req_q`, and the edge is detected in N+1.
  - The state is DRAIN from N+2, and `block_o` is high from N+2.
- DRAIN lasts at least 1 cycle, even when counters are already 0.
- `ndmreset_n` is low for exactly `AssertCycles` consecutive cycles, starting the cycle after DRAIN exits.
- With a timeout, DRAIN lasts exactly `DrainTimeout` cycles.
- HOLD lasts at least 1 cycle.
- Asserting `rst_n` mid-sequence aborts the sequence immediately (asynchronously) and restarts at ASSERT with a full stretch.

## Structure
- Package `ndmreset_pkg` holds the state enum `ndmreset_state_e`.
- Width helpers use `$clog2` locally.
- Sub-module `axi_outstanding_cnt` holds one saturating up/down counter (`inc`, `dec`, `clr`, `count`, `ovf`, `udf`). It is instantiated 2×`NumPorts` times.
- The shell drives `ndmreset_n` from this block instead of `rst_n` and ANDs `aw_valid`/`ar_valid` with `~block_o[i]`.

## Test plan
- **Power-on:** release `rst_n` → `ndmreset_n` low for 32 cycles, then high, `block_o=0` and `busy_o=0` one cycle after HOLD sees `ndreset_req=0`.
- **Idle request:** with no traffic, pulse `ndreset_req` for 1 cycle → `block_o` high at N+2, DRAIN lasts 1 cycle, `ndmreset_n` low for exactly 32 cycles.
- **Drain:**
  - Stimulus: 3 AW handshakes on port 1 without B responses, then `ndreset_req` asserted; B responses returned at +10, +20 and +30 cycles.
  - Required response: ASSERT is entered on the cycle after the third B; `timeout_o=0`.
- **Timeout:** with `DrainTimeout=64` and one AR never answered, DRAIN is exactly 64 cycles, `timeout_o=1`, the stretch follows, and the read counter is 0 after ASSERT.
- **Simultaneous events:**
  - `aw_hs` and `b_hs` in the same cycle leave the count unchanged.
  - A B handshake with the count at 0 sets `err_o` and holds the count at 0.
  - 17 AW handshakes without responses saturate the count at 16 and set `err_o`.
- **Reset mid-sequence:** assert `rst_n=0` mid-ASSERT (cycle 10 of 32) → outputs go to reset values immediately; after release a full 32-cycle stretch is produced.
